// File: rtl/ppu_background_fetch_sequencer.sv
// PPU background tile fetch: NT, AT, pattern lo/hi, two dots each, one bundle per 8 dots.
// Define PPU_BG_FETCH_INC_EN to drive o_inc_coarse_x; otherwise it is tied to 0.
module ppu_background_fetch_sequencer (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_ce,
    input  logic        i_run,
    input  logic [14:0] i_v,
    input  logic        i_bg_table,
    input  logic [7:0]  i_data,
    output logic [13:0] o_address,
    output logic        o_rd,
    output logic        o_tile_valid,
    output logic [7:0]  o_nt,
    output logic [1:0]  o_attr,
    output logic [7:0]  o_pat_lo,
    output logic [7:0]  o_pat_hi,
    output logic        o_inc_coarse_x,
    output logic        o_busy
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_NT_A,
        S_NT_D,
        S_AT_A,
        S_AT_D,
        S_PL_A,
        S_PL_D,
        S_PH_A,
        S_PH_D
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [14:0] r_v;
    logic [14:0] w_v_next;
    logic [13:0] r_address;
    logic [13:0] w_addr_next;
    logic        r_rd;
    logic        w_rd_next;
    logic [7:0]  r_nt;
    logic [1:0]  r_attr;
    logic [7:0]  r_lo;
    logic [7:0]  r_out_nt;
    logic [1:0]  r_out_attr;
    logic [7:0]  r_out_lo;
    logic [7:0]  r_out_hi;
    logic        r_tile_valid;
    logic [2:0]  w_at_shift;
    logic [7:0]  w_at_byte;
    logic        w_tile_done;

    always_comb begin
        w_next = r_state;
        if (i_ce) begin
            unique case (r_state)
                S_IDLE: w_next = i_run ? S_NT_A : S_IDLE;
                S_NT_A: w_next = S_NT_D;
                S_NT_D: w_next = S_AT_A;
                S_AT_A: w_next = S_AT_D;
                S_AT_D: w_next = S_PL_A;
                S_PL_A: w_next = S_PL_D;
                S_PL_D: w_next = S_PH_A;
                S_PH_A: w_next = S_PH_D;
                S_PH_D: w_next = i_run ? S_NT_A : S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Latch v only when a new tile starts so mid-tile scroll updates wait.
    always_comb begin
        w_v_next = r_v;
        if (w_next == S_NT_A && r_state != S_NT_A) begin
            w_v_next = i_v;
        end
    end

    // Address is precomputed from the next state so it is registered.
    always_comb begin
        w_addr_next = 14'h0000;
        w_rd_next   = 1'b0;
        unique case (w_next)
            S_NT_A, S_NT_D: begin
                w_addr_next = {2'b10, w_v_next[11:0]};
            end
            S_AT_A, S_AT_D: begin
                w_addr_next = {2'b10, w_v_next[11:10], 4'b1111,
                               w_v_next[9:7], w_v_next[4:2]};
            end
            S_PL_A, S_PL_D: begin
                w_addr_next = {i_bg_table, r_nt, 1'b0, w_v_next[14:12]};
            end
            S_PH_A, S_PH_D: begin
                w_addr_next = {i_bg_table, r_nt, 1'b1, w_v_next[14:12]};
            end
            default: w_addr_next = 14'h0000;
        endcase
        w_rd_next = (w_next == S_NT_D) || (w_next == S_AT_D) ||
                    (w_next == S_PL_D) || (w_next == S_PH_D);
    end

    assign w_at_shift  = {r_v[6], r_v[1], 1'b0};
    assign w_at_byte   = i_data >> w_at_shift;
    assign w_tile_done = i_ce && (r_state == S_PH_D);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= S_IDLE;
            r_v       <= 15'h0000;
            r_address <= 14'h0000;
            r_rd      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_v     <= w_v_next;
            if (i_ce) begin
                r_address <= w_addr_next;
                r_rd      <= w_rd_next;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_nt         <= 8'h00;
            r_attr       <= 2'b00;
            r_lo         <= 8'h00;
            r_out_nt     <= 8'h00;
            r_out_attr   <= 2'b00;
            r_out_lo     <= 8'h00;
            r_out_hi     <= 8'h00;
            r_tile_valid <= 1'b0;
        end else begin
            r_tile_valid <= w_tile_done;
            if (i_ce && r_state == S_NT_D) begin
                r_nt <= i_data;
            end
            if (i_ce && r_state == S_AT_D) begin
                r_attr <= w_at_byte[1:0];
            end
            if (i_ce && r_state == S_PL_D) begin
                r_lo <= i_data;
            end
            if (w_tile_done) begin
                r_out_nt   <= r_nt;
                r_out_attr <= r_attr;
                r_out_lo   <= r_lo;
                r_out_hi   <= i_data;
            end
        end
    end

`ifdef PPU_BG_FETCH_INC_EN
    logic r_inc;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_inc <= 1'b0;
        end else begin
            r_inc <= w_tile_done;
        end
    end

    assign o_inc_coarse_x = r_inc;
`else
    assign o_inc_coarse_x = 1'b0;
`endif

    assign o_address    = r_address;
    assign o_rd         = r_rd;
    assign o_tile_valid = r_tile_valid;
    assign o_nt         = r_out_nt;
    assign o_attr       = r_out_attr;
    assign o_pat_lo     = r_out_lo;
    assign o_pat_hi     = r_out_hi;
    assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_ppu_background_fetch_sequencer.sv
// Directed bench for ppu_background_fetch_sequencer.
// Memory model answers by address class: pattern (bit13=0), attribute, nametable.
module tb_ppu_background_fetch_sequencer;

`ifdef PPU_BG_FETCH_INC_EN
    localparam logic INC_EN = 1'b1;
`else
    localparam logic INC_EN = 1'b0;
`endif

    logic        i_clk;
    logic        i_reset_n;
    logic        i_ce;
    logic        i_run;
    logic [14:0] i_v;
    logic        i_bg_table;
    logic [7:0]  i_data;
    logic [13:0] o_address;
    logic        o_rd;
    logic        o_tile_valid;
    logic [7:0]  o_nt;
    logic [1:0]  o_attr;
    logic [7:0]  o_pat_lo;
    logic [7:0]  o_pat_hi;
    logic        o_inc_coarse_x;
    logic        o_busy;

    logic [7:0] mem_nt;
    logic [7:0] mem_at;
    logic [7:0] mem_pl;
    logic [7:0] mem_ph;

    int checks = 0;
    int errors = 0;

    ppu_background_fetch_sequencer dut (
        .i_clk          (i_clk),
        .i_reset_n      (i_reset_n),
        .i_ce           (i_ce),
        .i_run          (i_run),
        .i_v            (i_v),
        .i_bg_table     (i_bg_table),
        .i_data         (i_data),
        .o_address      (o_address),
        .o_rd           (o_rd),
        .o_tile_valid   (o_tile_valid),
        .o_nt           (o_nt),
        .o_attr         (o_attr),
        .o_pat_lo       (o_pat_lo),
        .o_pat_hi       (o_pat_hi),
        .o_inc_coarse_x (o_inc_coarse_x),
        .o_busy         (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always_comb begin
        i_data = mem_nt;
        if (!o_address[13]) begin
            i_data = o_address[3] ? mem_ph : mem_pl;
        end else if (o_address[9:6] == 4'hF) begin
            i_data = mem_at;
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_reset_n  = 1'b0;
        i_ce       = 1'b0;
        i_run      = 1'b0;
        i_v        = 15'h0;
        i_bg_table = 1'b0;
        mem_nt = 8'h00; mem_at = 8'h00; mem_pl = 8'h00; mem_ph = 8'h00;
        tick();
        tick();
        checks++;
        if ({o_address, o_rd, o_tile_valid, o_nt, o_attr, o_pat_lo,
             o_pat_hi, o_inc_coarse_x, o_busy} !== 49'h0) begin
            errors++;
            $display("FAIL reset_outputs: got addr=%h rd=%b busy=%b want all 0",
                     o_address, o_rd, o_busy);
        end
        i_reset_n = 1'b1;
        tick();
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b want 0", o_busy);
        end
    endtask

    task automatic test_single_tile();
        logic [13:0] exp_addr [8];
        exp_addr = '{14'h2C45, 14'h2C45, 14'h2FC1, 14'h2FC1,
                     14'h17E2, 14'h17E2, 14'h17EA, 14'h17EA};
        mem_nt = 8'h7E; mem_at = 8'hB4; mem_pl = 8'h55; mem_ph = 8'hAA;
        i_v = 15'h2C45; i_bg_table = 1'b1; i_ce = 1'b1; i_run = 1'b1;
        tick();
        i_run = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (o_address !== exp_addr[k] || o_rd !== k[0] ||
                o_tile_valid !== 1'b0) begin
                errors++;
                $display("FAIL single_seq[%0d]: got addr=%h rd=%b valid=%b want addr=%h rd=%b valid=0",
                         k, o_address, o_rd, o_tile_valid, exp_addr[k], k[0]);
            end
            tick();
        end
        checks++;
        if (o_tile_valid !== 1'b1 || o_nt !== 8'h7E || o_attr !== 2'd3 ||
            o_pat_lo !== 8'h55 || o_pat_hi !== 8'hAA) begin
            errors++;
            $display("FAIL single_bundle: got v=%b nt=%h at=%0d lo=%h hi=%h want v=1 nt=7e at=3 lo=55 hi=aa",
                     o_tile_valid, o_nt, o_attr, o_pat_lo, o_pat_hi);
        end
        checks++;
        if (o_inc_coarse_x !== INC_EN || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL single_inc_busy: got inc=%b busy=%b want inc=%b busy=0",
                     o_inc_coarse_x, o_busy, INC_EN);
        end
        tick();
        checks++;
        if (o_tile_valid !== 1'b0 || o_inc_coarse_x !== 1'b0 ||
            o_address !== 14'h0) begin
            errors++;
            $display("FAIL single_after: got v=%b inc=%b addr=%h want 0 0 0",
                     o_tile_valid, o_inc_coarse_x, o_address);
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int incs = 0;
        int idle_seen = 0;
        int edge_at [3];
        mem_nt = 8'h11; mem_at = 8'h00; mem_pl = 8'h22; mem_ph = 8'h33;
        i_v = 15'h0001; i_bg_table = 1'b0; i_ce = 1'b1; i_run = 1'b1;
        edge_at = '{0, 0, 0};
        tick();
        i_v = 15'h0002;
        tick();
        checks++;
        if (o_address !== 14'h2001) begin
            errors++;
            $display("FAIL b2b_hold_v: got %h want 2001", o_address);
        end
        for (int e = 2; e <= 26; e++) begin
            if (e == 17) i_run = 1'b0;
            tick();
            if (e == 8) begin
                checks++;
                if (o_address !== 14'h2002) begin
                    errors++;
                    $display("FAIL b2b_relatch: got %h want 2002", o_address);
                end
            end
            if (o_tile_valid) begin
                if (pulses < 3) edge_at[pulses] = e;
                pulses++;
            end
            if (o_inc_coarse_x) incs++;
            if (!o_busy && e < 24) idle_seen++;
        end
        checks++;
        if (pulses != 3 || edge_at[0] != 8 || edge_at[1] != 16 ||
            edge_at[2] != 24) begin
            errors++;
            $display("FAIL b2b_pulses: got n=%0d at %0d,%0d,%0d want 3 at 8,16,24",
                     pulses, edge_at[0], edge_at[1], edge_at[2]);
        end
        checks++;
        if (idle_seen != 0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: got gaps=%0d busy_end=%b want 0 0",
                     idle_seen, o_busy);
        end
        checks++;
        if (incs != (INC_EN ? 3 : 0)) begin
            errors++;
            $display("FAIL b2b_inc: got %0d want %0d", incs, INC_EN ? 3 : 0);
        end
    endtask

    task automatic test_ce_toggle();
        int c = 0;
        int rd_clocks = 0;
        int holds_bad = 0;
        logic [13:0] prev;
        mem_nt = 8'h7E; mem_at = 8'hB4; mem_pl = 8'h55; mem_ph = 8'hAA;
        i_v = 15'h2C45; i_bg_table = 1'b1; i_run = 1'b1;
        prev = o_address;
        while (c < 40) begin
            i_ce = (c % 2 == 0);
            tick();
            if (c == 0) i_run = 1'b0;
            if (!i_ce && o_address !== prev) holds_bad++;
            prev = o_address;
            c++;
            if (o_tile_valid) break;
            if (o_rd) rd_clocks++;
        end
        checks++;
        if (c != 17 || o_pat_hi !== 8'hAA) begin
            errors++;
            $display("FAIL ce_latency: got %0d clocks hi=%h want 17 hi=aa",
                     c, o_pat_hi);
        end
        checks++;
        if (rd_clocks != 8 || holds_bad != 0) begin
            errors++;
            $display("FAIL ce_durations: got rd=%0d holdbad=%0d want 8 0",
                     rd_clocks, holds_bad);
        end
        i_ce = 1'b0;
        tick();
        checks++;
        if (o_tile_valid !== 1'b0) begin
            errors++;
            $display("FAIL ce_pulse_width: got %b want 0", o_tile_valid);
        end
        i_ce = 1'b1;
        tick();
    endtask

    task automatic test_run_drop();
        mem_nt = 8'h3C; mem_at = 8'h00; mem_pl = 8'h01; mem_ph = 8'h02;
        i_v = 15'h0000; i_bg_table = 1'b0; i_ce = 1'b1; i_run = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        i_run = 1'b0;
        for (int k = 5; k < 9; k++) tick();
        checks++;
        if (o_tile_valid !== 1'b1 || o_nt !== 8'h3C || o_pat_hi !== 8'h02 ||
            o_busy !== 1'b0) begin
            errors++;
            $display("FAIL run_drop: got v=%b nt=%h hi=%h busy=%b want 1 3c 02 0",
                     o_tile_valid, o_nt, o_pat_hi, o_busy);
        end
        tick();
        checks++;
        if (o_busy !== 1'b0 || o_tile_valid !== 1'b0) begin
            errors++;
            $display("FAIL run_drop_idle: got busy=%b v=%b want 0 0",
                     o_busy, o_tile_valid);
        end
    endtask

    task automatic test_attr_quadrants();
        logic [14:0] vs [4];
        vs = '{15'h0000, 15'h0002, 15'h0040, 15'h0042};
        mem_nt = 8'h10; mem_at = 8'hE4; mem_pl = 8'h00; mem_ph = 8'h00;
        i_bg_table = 1'b0; i_ce = 1'b1;
        for (int q = 0; q < 4; q++) begin
            i_v = vs[q];
            i_run = 1'b1;
            tick();
            i_run = 1'b0;
            for (int k = 0; k < 8; k++) tick();
            checks++;
            if (o_tile_valid !== 1'b1 || o_attr !== q[1:0]) begin
                errors++;
                $display("FAIL attr_q%0d: got v=%b attr=%0d want v=1 attr=%0d",
                         q, o_tile_valid, o_attr, q);
            end
            tick();
        end
    endtask

    task automatic test_reset_midfetch();
        i_v = 15'h2C45; i_bg_table = 1'b1; i_ce = 1'b1; i_run = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        checks++;
        if (o_address !== 14'h2FC1 || o_rd !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre: got addr=%h rd=%b want 2fc1 1",
                     o_address, o_rd);
        end
        #2;
        i_reset_n = 1'b0;
        #1;
        checks++;
        if ({o_address, o_rd, o_tile_valid, o_nt, o_attr, o_pat_lo,
             o_pat_hi, o_inc_coarse_x, o_busy} !== 49'h0) begin
            errors++;
            $display("FAIL midreset_async: got addr=%h rd=%b nt=%h busy=%b want all 0",
                     o_address, o_rd, o_nt, o_busy);
        end
        i_run = 1'b0;
        tick();
        i_reset_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_tile();
        test_back_to_back();
        test_ce_toggle();
        test_run_drop();
        test_attr_quadrants();
        test_reset_midfetch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
